// File: rtl/weight_load_12_pkg.sv
// weight_load_12_pkg
//   Shared constants for the layer-12 coefficient loader: the per-layer
//   coefficient count and coefficient width, at the stock layer-12 values.
package weight_load_12_pkg;

  localparam int KERN_S_12   = 288;
  localparam int COEFF_WIDTH = 16;

endpackage

// File: rtl/weight_load_12_ram_sdp.sv
// ram_sdp
//   Simple dual-port buffer: one synchronous write port and one registered
//   read port with a read enable. Reads to addresses at or beyond MEM_SIZE
//   return zero. The read register holds its value while re_i is low.
//
// Ports
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears the read register only)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable
//   raddr_i  read address
//   rdata_o  registered read data (1-cycle latency)
module ram_sdp #(
  parameter int MEM_SIZE   = 288,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [AW:0] SIZE_W = (AW+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  in_range;

  // Address space is a power of two; entries past MEM_SIZE do not exist.
  assign in_range = ({1'b0, raddr_i} < SIZE_W);

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= in_range ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_load_12.sv
// weight_load_12
//   Drains one full coefficient set from an upstream ap_fifo into a local
//   buffer, then presents the buffer as a ROM (addr/ce/q, 1-cycle latency)
//   for the layer-12 convolution. A reload pulse re-arms loading; the old
//   contents are simply overwritten as new words arrive.
//
// Ports
//   ap_clk           clock
//   ap_rst           synchronous active-high reset
//   input_V_dout     FIFO read data
//   input_V_empty_n  FIFO not-empty
//   input_V_read     FIFO pop strobe
//   reload           single-cycle restart pulse
//   ready            buffer holds a complete coefficient set
//   load_count       words stored in the current load
//   weight_address   read address
//   weight_ce        read enable
//   weight_q         registered read data
module weight_load_12
  import weight_load_12_pkg::*;
#(
  parameter int MEM_SIZE   = KERN_S_12,
  parameter int DATA_WIDTH = COEFF_WIDTH,
  parameter int AW         = $clog2(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  input  logic                  reload,
  output logic                  ready,
  output logic [AW:0]           load_count,
  input  logic [AW-1:0]         weight_address,
  input  logic                  weight_ce,
  output logic [DATA_WIDTH-1:0] weight_q
);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(MEM_SIZE - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [0:0] state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        pop;

  // reload masks the strobe so the restart cycle never consumes a word.
  assign input_V_read = (state_q == ST_LOAD) && input_V_empty_n && !reload;
  assign pop          = input_V_read && input_V_empty_n;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (reload) begin
      state_d = ST_LOAD;
      count_d = '0;
    end else if (pop) begin
      count_d = count_q + ONE;
      if (count_q == LAST_IDX) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign ready      = (state_q == ST_READY);
  assign load_count = count_q;

  // Writes happen only in LOAD and reads only in READY, so the two ports
  // never touch the buffer in the same cycle.
  ram_sdp #(
    .MEM_SIZE  (MEM_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (AW)
  ) u_buf (
    .clk_i  (ap_clk),
    .rst_i  (ap_rst),
    .we_i   (pop),
    .waddr_i(count_q[AW-1:0]),
    .wdata_i(input_V_dout),
    .re_i   (weight_ce && ready),
    .raddr_i(weight_address),
    .rdata_o(weight_q)
  );

endmodule

// File: tb/tb_weight_load_12.sv
// tb_weight_load_12
//   Bench for weight_load_12: a queue-backed FIFO source with random stalls,
//   a coefficient-set model (stored words, words-in-set, last read value)
//   and directed phases covering load, readback, reload and reset.
module tb_weight_load_12;

  localparam int MEM = 288;
  localparam int AW  = $clog2(MEM);

  logic          ap_clk;
  logic          ap_rst;
  logic [15:0]   input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic          reload;
  logic          ready;
  logic [AW:0]   load_count;
  logic [AW-1:0] weight_address;
  logic          weight_ce;
  logic [15:0]   weight_q;

  weight_load_12 dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .input_V_dout   (input_V_dout),
    .input_V_empty_n(input_V_empty_n),
    .input_V_read   (input_V_read),
    .reload         (reload),
    .ready          (ready),
    .load_count     (load_count),
    .weight_address (weight_address),
    .weight_ce      (weight_ce),
    .weight_q       (weight_q)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int          total;
  int          bad;
  int          fifo[$];
  int          m_mem[MEM];
  int          m_cnt;
  int          m_q;
  int unsigned gate;
  logic [15:0] prev_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  // Offer the FIFO head, stalling at random according to gate (percent).
  task automatic present();
    if (fifo.size() > 0 && $urandom_range(99) < gate) begin
      input_V_empty_n = 1'b1;
      input_V_dout    = 16'(fifo[0]);
    end else begin
      input_V_empty_n = 1'b0;
      input_V_dout    = 16'($urandom);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then drive.
  task automatic cycle();
    logic exp_rd;
    int   a;
    @(negedge ap_clk);
    exp_rd = (m_cnt < MEM) && input_V_empty_n && !reload;
    chk("rd_strobe", 32'(input_V_read), 32'(exp_rd));
    chk("ready", 32'(ready), 32'(m_cnt == MEM));
    chk("load_count", 32'(load_count), 32'(m_cnt));
    chk("weight_q", 32'(weight_q), 32'(m_q));
    if (ap_rst) begin
      m_cnt = 0;
      m_q   = 0;
    end else begin
      if (weight_ce && m_cnt == MEM) begin
        a   = int'(weight_address);
        m_q = (a < MEM) ? m_mem[a] : 0;
      end
      if (reload) begin
        m_cnt = 0;
      end else if (exp_rd) begin
        m_mem[m_cnt] = fifo.pop_front();
        m_cnt++;
      end
    end
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    reload    = 1'b0;
    weight_ce = 1'b0;
    present();
  endtask

  task automatic run_until(input int target, input bit rnd);
    int n;
    n = 0;
    while (m_cnt < target && n < 5000) begin
      if (rnd) begin
        weight_ce      = 1'($urandom_range(1));
        weight_address = AW'($urandom_range(MEM + 31));
      end
      cycle();
      n++;
    end
    chk("load_progress", 32'(m_cnt >= target), 1);
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(base + i);
    present();
  endtask

  task automatic rd(input string tag, input int addr, input int want);
    weight_ce      = 1'b1;
    weight_address = AW'(addr);
    cycle();
    chk(tag, 32'(weight_q), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    gate  = 100;
    ap_rst          = 1'b1;
    reload          = 1'b0;
    weight_ce       = 1'b0;
    weight_address  = '0;
    input_V_empty_n = 1'b0;
    input_V_dout    = '0;
    repeat (2) begin
      @(posedge ap_clk);
      #1;
    end
    m_cnt  = 0;
    m_q    = 0;
    ap_rst = 1'b0;
    chk("rst_count", 32'(load_count), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_q", 32'(weight_q), 0);

    // Back-to-back load of 0..287 with extra words waiting behind it.
    for (int i = 0; i < MEM + 4; i++) fifo.push_back(i < MEM ? i : 9999);
    present();
    run_until(MEM, 1'b0);
    chk("t1_ready", 32'(ready), 1);
    chk("t1_count", 32'(load_count), MEM);
    repeat (3) begin
      chk("t1_no_pop", 32'(input_V_read), 0);
      cycle();
    end
    fifo.delete();
    present();

    // Same set with 50% stalls and random reads during the load.
    reload = 1'b1;
    cycle();
    gate = 50;
    fill(0, MEM);
    run_until(MEM, 1'b1);
    rd("t2_rd0", 0, 0);
    rd("t2_rd143", 143, 143);
    rd("t2_rd287", 287, 287);

    // A read while loading must leave weight_q untouched.
    reload = 1'b1;
    cycle();
    gate = 100;
    fill(500, MEM);
    run_until(10, 1'b0);
    prev_q         = weight_q;
    weight_ce      = 1'b1;
    weight_address = AW'(5);
    cycle();
    chk("t3_rd_loading", 32'(weight_q), 32'(prev_q));
    run_until(MEM, 1'b0);
    rd("t3_oob", 300, 0);
    rd("t3_rd5", 5, 505);

    // Reload from READY with the FIFO already offering a word.
    fill(1000, MEM);
    reload = 1'b1;
    #1;
    chk("t4_reload_no_pop", 32'(input_V_read), 0);
    cycle();
    chk("t4_ready_drop", 32'(ready), 0);
    chk("t4_count0", 32'(load_count), 0);
    run_until(MEM, 1'b0);
    rd("t4_rd7", 7, 1007);

    // Reload coincides with what would have been the final pop.
    reload = 1'b1;
    cycle();
    fifo.delete();
    gate = 50;
    fill(2000, 2 * MEM);
    run_until(MEM - 1, 1'b0);
    input_V_empty_n = 1'b1;
    input_V_dout    = 16'(fifo[0]);
    reload          = 1'b1;
    #1;
    chk("t5_rd_forced", 32'(input_V_read), 0);
    cycle();
    chk("t5_count0", 32'(load_count), 0);
    chk("t5_ready0", 32'(ready), 0);
    gate = 100;
    present();
    run_until(MEM, 1'b0);
    rd("t5_first", 0, 2000 + MEM - 1);
    rd("t5_second", 1, 2000 + MEM);
    for (int i = 0; i < 40; i++) begin
      weight_ce      = 1'($urandom_range(1));
      weight_address = AW'($urandom_range(MEM + 31));
      cycle();
    end
    rd("t5_rd200", 200, 2000 + MEM - 1 + 200);

    // Reset in the middle of a load discards the partial count.
    reload = 1'b1;
    cycle();
    fifo.delete();
    fill(3000, MEM + 100);
    run_until(100, 1'b0);
    ap_rst          = 1'b1;
    input_V_empty_n = 1'b0;
    cycle();
    chk("t6_count0", 32'(load_count), 0);
    chk("t6_ready0", 32'(ready), 0);
    chk("t6_q0", 32'(weight_q), 0);
    gate = 50;
    present();
    run_until(MEM, 1'b1);
    rd("t6_rd0", 0, 3100);
    rd("t6_rd287", 287, 3387);
    rd("t6_rd150", 150, 3250);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
